// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter; optional packet lock via UART_ARB_LOCK_EN
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]     req_lock,
`endif
  output logic [NREQ-1:0]     ack,
  input  logic                tx_ready,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic [IDW-1:0]      grant_id,
  output logic                busy,
  output logic                err_timeout
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    WAIT_ACC  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt;
  logic [IDW-1:0]  grant_nxt;
  logic [IDW-1:0]  grant_inc;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            found;
  logic [7:0]      data_nxt;
  logic            start_nxt;
  logic            err_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [TW-1:0]   tmo_nxt;
  logic [7:0]      src_byte [NREQ];
`ifdef UART_ARB_LOCK_EN
  logic            locked;
  logic            lock_nxt;
`endif

  // Split the flat data bus into one byte per source
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      src_byte[i] = req_data[8*i +: 8];
    end
  end

  // Pointer to the source after the last accepted winner, wrapping at NREQ
  assign grant_inc = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // Round-robin search from ptr; a held lock restricts the choice to the locked source
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (locked) begin
      winner = grant_id;
      found  = req[grant_id];
    end
`endif
  end

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    data_nxt  = tx_data;
    start_nxt = 1'b0;
    err_nxt   = 1'b0;
    ack_nxt   = '0;
    tmo_nxt   = tmo_cnt;
`ifdef UART_ARB_LOCK_EN
    lock_nxt  = locked;
`endif
    case (state)
      ARB: begin
        if (tx_ready && found) begin
          grant_nxt = winner;
          data_nxt  = src_byte[winner];
          start_nxt = 1'b1;
          tmo_nxt   = '0;
          state_nxt = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        if (!tx_ready) begin
          ack_nxt[grant_id] = 1'b1;
          ptr_nxt           = grant_inc;
          state_nxt         = WAIT_DONE;
`ifdef UART_ARB_LOCK_EN
          lock_nxt          = req_lock[grant_id];
`endif
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = ARB;
`ifdef UART_ARB_LOCK_EN
          lock_nxt  = 1'b0;
`endif
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_nxt = ARB;
        end
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // State and registered outputs; reset acts immediately, even mid-transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      ptr         <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      ack         <= '0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
`ifdef UART_ARB_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_id    <= grant_nxt;
      tx_data     <= data_nxt;
      tx_start    <= start_nxt;
      ack         <= ack_nxt;
      err_timeout <= err_nxt;
      tmo_cnt     <= tmo_nxt;
`ifdef UART_ARB_LOCK_EN
      locked      <= lock_nxt;
`endif
    end
  end

  assign busy = (state != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter with a transaction-level model
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic [NREQ-1:0]   ack;
  logic              tx_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              err_timeout;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .ack(ack), .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Source and transmitter stimulus state
  int         left [NREQ];
  logic [7:0] sdata [NREQ];
  bit         rand_mode = 1'b0;
  bit         lock_mode = 1'b0;
  bit         tx_stuck  = 1'b0;
  int         acc_cfg = 2, len_cfg = 4, acc_cnt = 0, len_cnt = 0, cur_len = 0;

  // Observed transactions
  int         st_id [$];
  logic [7:0] st_data [$];
  int         st_cyc [$];
  int         err_cyc [$];
  int         ack_cnt [NREQ];

  // Model expectations
  logic [NREQ-1:0] e_ack;
  logic            e_start, e_busy, e_err;
  logic [7:0]      e_data;
  logic [IDW-1:0]  e_grant;
  int              m_ptr;
  bit              m_lock;

  task automatic m_clear();
    e_ack = '0; e_start = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    e_data = '0; e_grant = '0; m_ptr = 0; m_lock = 1'b0;
  endtask

  task automatic m_step(output bit ab);
    @(posedge clk or negedge rst_n);
    e_start = 1'b0; e_ack = '0; e_err = 1'b0;
    ab = !rst_n;
    if (ab) m_clear();
  endtask

  function automatic int m_pick();
    if (m_lock) return req[e_grant] ? int'(e_grant) : -1;
    for (int k = 0; k < NREQ; k++)
      if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // Transaction-level model: grant, acceptance window, transmit, back to idle
  initial begin : model
    bit ab, accepted, timed_out;
    int w;
    m_clear();
    forever begin
      m_step(ab);
      if (ab || !tx_ready) continue;
      w = m_pick();
      if (w < 0) continue;
      e_grant = IDW'(w); e_data = req_data[8*w +: 8]; e_start = 1'b1; e_busy = 1'b1;
      accepted = 1'b0; timed_out = 1'b0;
      for (int k = 0; k < TIMEOUT && !accepted && !timed_out && !ab; k++) begin
        m_step(ab);
        if (!ab) begin
          if (!tx_ready) begin
            e_ack[w] = 1'b1; m_ptr = (w + 1) % NREQ; accepted = 1'b1;
`ifdef UART_ARB_LOCK_EN
            m_lock = req_lock[w];
`endif
          end else if (k == TIMEOUT - 1) begin
            e_err = 1'b1; e_busy = 1'b0; m_lock = 1'b0; timed_out = 1'b1;
          end
        end
      end
      if (accepted) begin
        do m_step(ab); while (!ab && !tx_ready);
        if (!ab) e_busy = 1'b0;
      end
    end
  end

  task automatic expect_eq(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare();
    cyc++;
    n_cmp++;
    if ({ack, tx_start, tx_data, grant_id, busy, err_timeout} !==
        {e_ack, e_start, e_data, e_grant, e_busy, e_err}) begin
      n_bad++;
      $display("FAIL outputs cyc=%0d: ack=%b start=%b data=%h gid=%0d busy=%b err=%b, model ack=%b start=%b data=%h gid=%0d busy=%b err=%b",
               cyc, ack, tx_start, tx_data, grant_id, busy, err_timeout,
               e_ack, e_start, e_data, e_grant, e_busy, e_err);
    end
    if (tx_start === 1'b1) begin
      st_id.push_back(int'(grant_id)); st_data.push_back(tx_data); st_cyc.push_back(cyc);
    end
    for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
    if (err_timeout === 1'b1) err_cyc.push_back(cyc);
  endtask

  task automatic apply_src();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (left[i] > 0);
      req_data[8*i +: 8] = sdata[i];
`ifdef UART_ARB_LOCK_EN
      req_lock[i] = lock_mode && (left[i] > 1);
`endif
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] && left[i] > 0) begin left[i]--; sdata[i] = 8'($urandom); end
      if (rand_mode) begin
        if (left[i] == 0 && $urandom_range(0, 5) == 0) begin
          left[i] = $urandom_range(1, 3); sdata[i] = 8'($urandom);
        end else if (left[i] > 0 && !lock_mode && $urandom_range(0, 40) == 0) begin
          left[i] = 0;
        end
      end
    end
    apply_src();
    if (len_cnt > 0) begin
      len_cnt--;
      if (len_cnt == 0) tx_ready = 1'b1;
    end else if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) begin tx_ready = 1'b0; len_cnt = cur_len; end
    end else if (tx_start && !tx_stuck) begin
      if (!(rand_mode && $urandom_range(0, 15) == 0)) begin
        acc_cnt = rand_mode ? $urandom_range(1, 4) : acc_cfg;
        cur_len = rand_mode ? $urandom_range(1, 5) : len_cfg;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    #2;
    drive();
  endtask

  task automatic mon_clear();
    st_id.delete(); st_data.delete(); st_cyc.delete(); err_cyc.delete();
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NREQ; i++) if (left[i] != 0) return 1'b0;
    return !busy && tx_ready && acc_cnt == 0 && len_cnt == 0;
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int c = 0;
    do begin cycle(); c++; end while (!all_idle() && c < maxc);
    expect_eq(nm, int'(all_idle()), 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic int qid(input int k);
    return (k < st_id.size()) ? st_id[k] : -1;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int exp2 [8];
    int c;
    exp2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_n = 1'b0; tx_ready = 1'b1; req = '0; req_data = '0;
`ifdef UART_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin left[i] = 0; sdata[i] = 8'h00; ack_cnt[i] = 0; end
    repeat (3) cycle();
    rst_n = 1'b1;
    expect_eq("reset_busy", int'(busy), 0);
    expect_eq("reset_gid", int'(grant_id), 0);
    expect_eq("reset_data", int'(tx_data), 0);

    // 1: single byte A5 from source 0, slow transmitter
    acc_cfg = 2; len_cfg = 100; mon_clear();
    sdata[0] = 8'hA5; left[0] = 1; apply_src();
    wait_idle("t1_idle", 200);
    expect_eq("t1_starts", st_id.size(), 1);
    expect_eq("t1_gid", qid(0), 0);
    expect_eq("t1_data", (st_data.size() > 0) ? int'(st_data[0]) : -1, 8'hA5);
    expect_eq("t1_ack0", ack_cnt[0], 1);
    expect_eq("t1_ack_other", ack_cnt[1] + ack_cnt[2] + ack_cnt[3], 0);
    expect_eq("t1_busy", int'(busy), 0);

    // 2: all four sources, two bytes each, from ptr=0
    pulse_reset(); mon_clear(); acc_cfg = 1; len_cfg = 3;
    for (int i = 0; i < NREQ; i++) begin left[i] = 2; sdata[i] = 8'($urandom); end
    apply_src();
    wait_idle("t2_idle", 300);
    for (int k = 0; k < 8; k++) expect_eq($sformatf("t2_grant%0d", k), qid(k), exp2[k]);
    for (int i = 0; i < NREQ; i++) expect_eq($sformatf("t2_ack%0d", i), ack_cnt[i], 2);

    // 3: serve source 2 (ptr -> 3), then 3 and 0 compete: 3 then wrap to 0
    mon_clear(); left[2] = 1; apply_src(); wait_idle("t3a_idle", 100);
    left[0] = 1; left[3] = 1; apply_src(); wait_idle("t3b_idle", 100);
    expect_eq("t3_g0", qid(0), 2);
    expect_eq("t3_g1", qid(1), 3);
    expect_eq("t3_g2", qid(2), 0);

    // 4: transmitter never accepts; timeout then re-grant of the same source
    mon_clear(); tx_stuck = 1'b1; left[1] = 1; apply_src();
    c = 0;
    while ((err_cyc.size() < 1 || st_id.size() < 2) && c < 80) begin cycle(); c++; end
    expect_eq("t4_err_seen", int'(err_cyc.size() >= 1 && st_id.size() >= 2), 1);
    expect_eq("t4_err_delay", (err_cyc.size() > 0 && st_cyc.size() > 0) ? err_cyc[0] - st_cyc[0] : -1, TIMEOUT);
    expect_eq("t4_regrant_delay", (st_cyc.size() > 1) ? st_cyc[1] - st_cyc[0] : -1, TIMEOUT + 1);
    expect_eq("t4_regrant_id", qid(1), 1);
    expect_eq("t4_no_ack", ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3], 0);
    tx_stuck = 1'b0;
    wait_idle("t4_idle", 200);
    expect_eq("t4_ack1", ack_cnt[1], 1);

    // 5: reset while the transmitter is still busy with an accepted byte
    mon_clear(); acc_cfg = 2; len_cfg = 20; left[2] = 1; apply_src();
    c = 0;
    while (ack_cnt[2] == 0 && c < 50) begin cycle(); c++; end
    expect_eq("t5_acked", ack_cnt[2], 1);
    cycle(); cycle();
    left[0] = 1; left[3] = 1; apply_src();
    rst_n = 1'b0;
    #1;
    expect_eq("t5_rst_busy", int'(busy), 0);
    expect_eq("t5_rst_start", int'(tx_start), 0);
    expect_eq("t5_rst_data", int'(tx_data), 0);
    expect_eq("t5_rst_gid", int'(grant_id), 0);
    expect_eq("t5_rst_pulses", int'({ack, err_timeout}), 0);
    cycle();
    rst_n = 1'b1;
    mon_clear();
    c = 0;
    while (!tx_ready && c < 40) begin cycle(); c++; end
    expect_eq("t5_hold_until_ready", st_id.size(), 0);
    wait_idle("t5_idle", 200);
    expect_eq("t5_g0", qid(0), 0);
    expect_eq("t5_g1", qid(1), 3);

`ifdef UART_ARB_LOCK_EN
    // 6: locked 3-byte packet from source 1 while 0 and 2 also request
    lock_mode = 1'b1; acc_cfg = 1; len_cfg = 2;
    mon_clear(); left[0] = 1; apply_src(); wait_idle("t6a_idle", 100);
    mon_clear(); left[0] = 1; left[1] = 3; left[2] = 1; apply_src();
    wait_idle("t6_idle", 200);
    expect_eq("t6_g0", qid(0), 1);
    expect_eq("t6_g1", qid(1), 1);
    expect_eq("t6_g2", qid(2), 1);
    expect_eq("t6_g3", qid(3), 2);
    expect_eq("t6_g4", qid(4), 0);
`endif

    // 7: random traffic, random transmitter timing and occasional ignored starts
    mon_clear(); rand_mode = 1'b1;
    repeat (4000) cycle();
    rand_mode = 1'b0;
    wait_idle("t7_drain", 600);
    expect_eq("t7_activity", int'((ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]) > 50), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
